// File: rtl/mc_pkg.sv
// ============================================================================
// Module : mc_pkg
// Brief  : State, opcode, funct and select encodings for the multi-cycle
//          MIPS controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CL_R    = 4'd0,
        CL_ADDI = 4'd1,
        CL_ORI  = 4'd2,
        CL_LUI  = 4'd3,
        CL_LW   = 4'd4,
        CL_SW   = 4'd5,
        CL_BEQ  = 4'd6,
        CL_BNE  = 4'd7,
        CL_J    = 4'd8,
        CL_JAL  = 4'd9,
        CL_JR   = 4'd10,
        CL_ILL  = 4'd15
    } iclass_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;
    localparam logic [4:0] ALU_SLL = 5'd5;
    localparam logic [4:0] ALU_SRL = 5'd6;
    localparam logic [4:0] ALU_LUI = 5'd7;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_RS  = 2'b11;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HI   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_if.sv
// ============================================================================
// Module : mc_ctrl_if
// Brief  : Controller <-> datapath signal bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mc_ctrl_if;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        dm_rdy;
    logic        PCWr;
    logic        IRWr;
    logic        RFWr;
    logic        DMWr;
    logic [1:0]  NPCOp;
    logic [1:0]  RegDst;
    logic [1:0]  WDSel;
    logic        BSel;
    logic        Shift;
    logic [1:0]  ExtOp;
    logic [4:0]  ALUOp;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] instret;

    modport master (
        input  op, funct, zero, dm_rdy,
        output PCWr, IRWr, RFWr, DMWr, NPCOp, RegDst, WDSel,
               BSel, Shift, ExtOp, ALUOp, state, illegal, instret
    );

    modport slave (
        output op, funct, zero, dm_rdy,
        input  PCWr, IRWr, RFWr, DMWr, NPCOp, RegDst, WDSel,
               BSel, Shift, ExtOp, ALUOp, state, illegal, instret
    );
endinterface

`default_nettype wire

// File: rtl/mc_decode.sv
// ============================================================================
// Module : mc_decode
// Brief  : Combinational op/funct decode into instruction class and ALUOp.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output iclass_e    cls_o,
    output logic [4:0] alu_op_o,
    output logic       shift_o,
    output logic       legal_o
);

    always_comb begin
        cls_o    = CL_ILL;
        alu_op_o = ALU_ADD;
        shift_o  = 1'b0;
        case (op_i)
            OP_R: begin
                cls_o = CL_R;
                case (funct_i)
                    F_ADD:   alu_op_o = ALU_ADD;
                    F_SUB:   alu_op_o = ALU_SUB;
                    F_AND:   alu_op_o = ALU_AND;
                    F_OR:    alu_op_o = ALU_OR;
                    F_SLT:   alu_op_o = ALU_SLT;
                    F_SLL:   begin alu_op_o = ALU_SLL; shift_o = 1'b1; end
                    F_SRL:   begin alu_op_o = ALU_SRL; shift_o = 1'b1; end
                    F_JR:    cls_o = CL_JR;
                    default: cls_o = CL_ILL;
                endcase
            end
            OP_LW:   cls_o = CL_LW;
            OP_SW:   cls_o = CL_SW;
            OP_ADDI: cls_o = CL_ADDI;
            OP_ORI:  begin cls_o = CL_ORI; alu_op_o = ALU_OR; end
            OP_LUI:  begin cls_o = CL_LUI; alu_op_o = ALU_LUI; end
            OP_BEQ:  begin cls_o = CL_BEQ; alu_op_o = ALU_SUB; end
            OP_BNE:  begin cls_o = CL_BNE; alu_op_o = ALU_SUB; end
            OP_J:    cls_o = CL_J;
            OP_JAL:  cls_o = CL_JAL;
            default: cls_o = CL_ILL;
        endcase
        legal_o = (cls_o != CL_ILL);
    end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module : mc_ctrl
// Brief  : Multi-cycle FETCH/DECODE/EXE/MEM/WB controller with handshaked DM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mc_ctrl
    import mc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mc_ctrl_if.master bus
);

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;

    iclass_e     w_cls;
    logic [4:0]  w_alu_op;
    logic        w_shift;
    logic        w_legal;

    logic        w_pc_wr, w_ir_wr, w_rf_wr, w_dm_wr;
    logic [1:0]  w_npc_op, w_reg_dst, w_wd_sel, w_ext_op;
    logic        w_bsel, w_shift_sel;
    logic [4:0]  w_alu_sel;

    mc_decode u_decode (
        .op_i     (bus.op),
        .funct_i  (bus.funct),
        .cls_o    (w_cls),
        .alu_op_o (w_alu_op),
        .shift_o  (w_shift),
        .legal_o  (w_legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        w_pc_wr     = 1'b0;
        w_ir_wr     = 1'b0;
        w_rf_wr     = 1'b0;
        w_dm_wr     = 1'b0;
        w_npc_op    = NPC_PC4;
        w_reg_dst   = RD_RT;
        w_wd_sel    = WD_ALU;
        w_ext_op    = EXT_ZERO;
        w_bsel      = 1'b0;
        w_shift_sel = 1'b0;
        w_alu_sel   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                w_ir_wr = 1'b1;
                w_pc_wr = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXE;
                case (w_cls)
                    CL_J: begin
                        w_pc_wr  = 1'b1;
                        w_npc_op = NPC_J;
                        state_d  = S_FETCH;
                    end
                    CL_JAL: begin
                        w_pc_wr   = 1'b1;
                        w_npc_op  = NPC_J;
                        w_rf_wr   = 1'b1;
                        w_reg_dst = RD_R31;
                        w_wd_sel  = WD_PC;
                        state_d   = S_FETCH;
                    end
                    CL_JR: begin
                        w_pc_wr  = 1'b1;
                        w_npc_op = NPC_RS;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        if (!w_legal) begin
                            illegal_d = 1'b1;
                            state_d   = S_TRAP;
                        end
                    end
                endcase
            end
            S_EXE: begin
                w_alu_sel = w_alu_op;
                state_d   = S_WB;
                case (w_cls)
                    CL_R: begin
                        w_shift_sel = w_shift;
                        w_bsel      = w_shift;
                    end
                    CL_ADDI:      begin w_bsel = 1'b1; w_ext_op = EXT_SIGN; end
                    CL_LW, CL_SW: begin
                        w_bsel   = 1'b1;
                        w_ext_op = EXT_SIGN;
                        state_d  = S_MEM;
                    end
                    CL_ORI:       w_bsel = 1'b1;
                    CL_LUI:       begin w_bsel = 1'b1; w_ext_op = EXT_HI; end
                    CL_BEQ: begin
                        w_npc_op = NPC_BR;
                        w_pc_wr  = bus.zero;
                        state_d  = S_FETCH;
                    end
                    CL_BNE: begin
                        w_npc_op = NPC_BR;
                        w_pc_wr  = !bus.zero;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                // Keep the address computation steady while the memory works.
                w_bsel   = 1'b1;
                w_ext_op = EXT_SIGN;
                w_dm_wr  = (w_cls == CL_SW);
                if (bus.dm_rdy) begin
                    state_d = (w_cls == CL_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                w_rf_wr = 1'b1;
                state_d = S_FETCH;
                if (w_cls == CL_R) begin
                    w_reg_dst = RD_RD;
                end else if (w_cls == CL_LW) begin
                    w_wd_sel = WD_DM;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        instret_d = instret_q;
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // Reset gates the enables so the FETCH reset state cannot write anything.
    assign bus.PCWr    = w_pc_wr & rst;
    assign bus.IRWr    = w_ir_wr & rst;
    assign bus.RFWr    = w_rf_wr & rst;
    assign bus.DMWr    = w_dm_wr & rst;
    assign bus.NPCOp   = w_npc_op;
    assign bus.RegDst  = w_reg_dst;
    assign bus.WDSel   = w_wd_sel;
    assign bus.BSel    = w_bsel;
    assign bus.Shift   = w_shift_sel;
    assign bus.ExtOp   = w_ext_op;
    assign bus.ALUOp   = w_alu_sel;
    assign bus.state   = state_q;
    assign bus.illegal = illegal_q;
    assign bus.instret = instret_q;

endmodule

`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle controller for the MIPS datapath. It sequences one instruction at a time through FETCH/DECODE/EXE/MEM/WB, driving the PC, IR, register-file and data-memory write enables plus the datapath mux selects. It replaces the single-cycle combinational decoder when the core moves to a shared-ALU, multi-cycle datapath with a handshaked data memory. It sits beside the PC, IR, RF, EXT, ALU and DM instances at core top level.

## Interface
Parameters:
- none; encodings come from `mc_pkg`.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]; stable from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- dm_rdy  in  1  data memory done; sampled only in MEM
- PCWr  out  1  PC load enable
- IRWr  out  1  IR load enable
- RFWr  out  1  register-file write enable
- DMWr  out  1  data-memory write request
- NPCOp  out  2  next PC: 00 PC+4, 01 branch target, 10 {PC[31:28],imm26,00}, 11 rs
- RegDst  out  2  write register: 00 rt, 01 rd, 10 r31
- WDSel  out  2  write data: 00 ALU, 01 DM, 10 PC register (already PC+4)
- BSel  out  1  ALU B: 0 rt, 1 EXT output
- Shift  out  1  ALU A = rt, EXT input = shamt
- ExtOp  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- ALUOp  out  5  ALU function (mc_pkg)
- state  out  3  current state (debug)
- illegal  out  1  sticky unsupported-opcode flag
- instret  out  32  retired-instruction counter

## Operation
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, TRAP=7.
- Outputs are combinational from the registered state, op, funct and zero. Unlisted enables are 0; unlisted selects are don't-care (driven 0).
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state is DECODE.
- DECODE:
  - j: PCWr, NPCOp=10, then FETCH.
  - jal: as j, plus RFWr, RegDst=10, WDSel=10.
  - jr (R, funct 001000): PCWr, NPCOp=11, then FETCH.
  - Supported op: go to EXE.
  - Any other op or R funct: illegal<=1, go to TRAP.
- EXE:
  - R: ALUOp from funct; sll/srl also set Shift=1, BSel=1, ExtOp=00.
  - addi, lw, sw: BSel=1, ExtOp=01, ADD.
  - ori: BSel=1, ExtOp=00, OR.
  - lui: BSel=1, ExtOp=10, ADD with A forced via ALU_LUI.
  - beq/bne: SUB, NPCOp=01, PCWr = zero (beq) or !zero (bne), then FETCH.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - Holds the ALU address.
  - sw: DMWr=1 every cycle until dm_rdy.
  - Stays in MEM while dm_rdy=0.
  - On dm_rdy=1: lw goes to WB, sw goes to FETCH.
- WB:
  - RFWr=1.
  - R-type: RegDst=01, WDSel=00.
  - I-ALU: RegDst=00, WDSel=00.
  - lw: RegDst=00, WDSel=01.
  - Next state is FETCH.
- instret increments by 1 on every transition into FETCH from DECODE/EXE/MEM/WB. It wraps modulo 2^32.
- TRAP: all enables 0; held until reset.

## Timing
- Reset (rst=0, async): state=FETCH, illegal=0, instret=0. All write enables are forced 0 while rst=0, even though state=FETCH.
- First fetch happens on the first rising edge after rst deasserts.
- Latency in cycles (no memory wait):
  - j/jal/jr: 2
  - beq/bne: 3
  - R/I-ALU: 4
  - sw: 4
  - lw: 5
  - Each dm_rdy=0 cycle in MEM adds 1 to sw/lw.
- Branch decision uses zero in the EXE cycle only.
- dm_rdy is ignored outside MEM. dm_rdy=1 on the first MEM cycle completes with no wait.
- Reset mid-instruction aborts immediately; no partial RF/DM write occurs after rst falls.

## Structure
- `mc_pkg`:
  - State enum.
  - Opcode constants: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, ori 001101, lui 001111, j 000010, jal 000011.
  - Funct constants: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010, jr 001000.
  - ALUOp, NPCOp, RegDst, WDSel and ExtOp encodings.
- One sub-module, `mc_decode`: pure combinational op/funct → instruction class + ALUOp + legal flag. `mc_ctrl` holds the state register, instret, illegal, and the per-state output logic.

## Test plan
- Reset: hold rst=0 for 3 cycles with dm_rdy=1 → state=0, all enables 0, instret=0. Release → cycle 1 IRWr=PCWr=1.
- add (op 0, funct 100000) → states 0,1,2,4,0. WB: RFWr=1, RegDst=01, WDSel=00. instret=1.
- lw with dm_rdy low for 2 MEM cycles → MEM held 3 cycles, then WB with WDSel=01, RegDst=00. Total 7 cycles.
- sw with dm_rdy=1 immediately → DMWr=1 for exactly 1 cycle, then FETCH. No RFWr in the whole sequence.
- beq with zero=1, then bne with zero=1 → first gives PCWr=1, NPCOp=01 in EXE; second gives PCWr=0. Both return to FETCH after 3 cycles.
- jal, then op 111111 → jal: DECODE has PCWr=RFWr=1, RegDst=10, WDSel=10. Illegal op: illegal=1, state=7 held, enables 0 until rst.
